pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the main decoder/control unit in the single-cycle MIPS datapath.
- Holds the architectural PC and fetches instructions from instruction memory using a req/ready handshake.
- Presents each instruction to decode and holds it stable until decode/execute retires it.
- On retire, selects the next PC from the control unit's 2-bit pcsrc: 00 = PC+4, 01 = branch, 10 = jr, 11 = j/jal.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pcsrc  input  2  next-PC select from the control unit; sampled only on retire.
- branch_imm  input  32  sign-extended 16-bit immediate from the current instruction.
- jr_target  input  32  rs register value used for jr.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ready  input  1  memory has returned data this cycle.
- imem_rdata  input  32  instruction word; valid when imem_ready=1.
- instr  output  32  held instruction presented to decode.
- instr_valid  output  1  instr is valid and awaiting retire.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc+4, combinational; used as the jal link value.
- retire  input  1  decode/execute has consumed instr this cycle.
- retired_cnt  output  CNT_W  number of instructions retired since reset.

Behaviour:
- Reset values (asynchronous on rst=1):
  - pc=RESET_PC
  - instr=0
  - instr_valid=0
  - imem_req=0
  - retired_cnt=0
  - state=RESET_WAIT
- States and transitions:
  - RESET_WAIT: imem_req=0. Goes to FETCH on the first clock edge after rst deasserts.
  - FETCH: imem_req=1 and imem_addr=pc.
    - On an edge where imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to HOLD.
    - Otherwise stay in FETCH; request, address and pc stay stable.
  - HOLD: imem_req=0, instr_valid=1, instr stable.
    - On an edge where retire=1: pc<=next_pc, instr_valid<=0, retired_cnt<=retired_cnt+1, go to FETCH.
- Minimum throughput: 2 cycles per instruction (one FETCH cycle with ready=1, then one HOLD cycle with retire=1).
- next_pc, combinational, all arithmetic modulo 2^32:
  - 00: pc_plus4
  - 01: pc_plus4 + {branch_imm[29:0], 2'b00}
  - 10: jr_target
  - 11: {pc_plus4[31:28], instr[25:0], 2'b00}
- Boundary conditions:
  - retire in RESET_WAIT or FETCH is ignored: no pc change, no count.
  - imem_ready while not in FETCH is ignored.
  - PC wrap: pc=32'hFFFF_FFFC with pcsrc=00 gives next pc=0.
  - retired_cnt wraps from all-ones to 0.
  - Reset mid-fetch or mid-hold: outstanding request abandoned, instr_valid drops immediately (asynchronous), state returns to RESET_WAIT.
  - pcsrc, branch_imm and jr_target are don't-care except on the retire edge.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - On a retire edge where pcsrc=10 and jr_target[1:0]!=0: pc is not updated, misalign<=1, state goes to TRAP.
  - TRAP: imem_req=0, instr_valid=0. Left only by reset.
  - retired_cnt still increments for the trapping jr.
- Not defined:
  - No misalign port.
  - jr loads jr_target verbatim, including nonzero bits [1:0].

Test Plan:
- Sequential fetch: RESET_PC=0, memory answers ready in the same cycle, retire every HOLD cycle with pcsrc=00 → imem_addr sequence 0,4,8,C; retired_cnt=4 after 8 cycles.
- Memory wait states: ready held low 3 cycles in FETCH → imem_req stays 1, imem_addr constant, instr_valid=0 throughout; instr latched on the 4th cycle.
- Taken branch backward: pc=0x100, branch_imm=32'hFFFF_FFFE, pcsrc=01 at retire → pc=0xFC.
- Jump with PC region: pc=0x4000_0010, instr[25:0]=26'h0000040, pcsrc=11 → pc=0x4000_0100. Then jr with jr_target=0x20, pcsrc=10 → pc=0x20.
- Wrap and ignored retire: pc=0xFFFF_FFFC, pcsrc=00 → pc=0. retire pulsed during FETCH → no pc or count change.
- Reset in HOLD → instr_valid=0 with no clock edge; pc=RESET_PC; first fetch re-issued at RESET_PC. With PC_MISALIGN_TRAP_EN, jr_target=0x22 → misalign=1, pc unchanged, imem_req stays 0.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// MIPS instruction-fetch stage: holds the PC, fetches over a req/ready bus and holds instr until retire.
// Optional macro PC_MISALIGN_TRAP_EN adds a sticky trap on a misaligned jr target.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    pc_fetch_unit_if.master    imem,
    input  logic [1:0]         pcsrc_i,
    input  logic [31:0]        branch_imm_i,
    input  logic [31:0]        jr_target_i,
    output logic [31:0]        instr_o,
    output logic               instr_valid_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o,
    input  logic               retire_i,
`ifdef PC_MISALIGN_TRAP_EN
    output logic               misalign_o,
`endif
    output logic [CNT_W-1:0]   retired_cnt_o
);

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'd0,
        ST_FETCH      = 2'd1,
        ST_HOLD       = 2'd2,
        ST_TRAP       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        instr_q;
    logic               instr_valid_q;
    logic               imem_req_q;
    logic [CNT_W-1:0]   retired_cnt_q;
    logic [31:0]        pc_plus4_d;
    logic [31:0]        next_pc_d;
    logic               unused_bits;

    assign pc_plus4_d  = pc_q + 32'd4;
    // Only the low 30 bits of the immediate survive the word shift.
    assign unused_bits = ^branch_imm_i[31:30];

    always_comb begin
        next_pc_d = pc_plus4_d;
        unique case (pcsrc_i)
            2'b00:   next_pc_d = pc_plus4_d;
            2'b01:   next_pc_d = pc_plus4_d + {branch_imm_i[29:0], 2'b00};
            2'b10:   next_pc_d = jr_target_i;
            2'b11:   next_pc_d = {pc_plus4_d[31:28], instr_q[25:0], 2'b00};
            default: next_pc_d = pc_plus4_d;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;
    logic jr_misaligned;
    assign jr_misaligned = (pcsrc_i == 2'b10) && (jr_target_i[1:0] != 2'b00);
    assign misalign_o    = misalign_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RESET_WAIT;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            retired_cnt_q <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_RESET_WAIT: begin
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        instr_q       <= imem.imem_rdata;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state_q       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (retire_i) begin
                        retired_cnt_q <= retired_cnt_q + CNT_ONE;
                        instr_valid_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                        if (jr_misaligned) begin
                            // PC keeps pointing at the faulting jr; only reset leaves TRAP.
                            misalign_q <= 1'b1;
                            state_q    <= ST_TRAP;
                        end else begin
                            pc_q       <= next_pc_d;
                            imem_req_q <= 1'b1;
                            state_q    <= ST_FETCH;
                        end
`else
                        pc_q       <= next_pc_d;
                        imem_req_q <= 1'b1;
                        state_q    <= ST_FETCH;
`endif
                    end
                end
                ST_TRAP: begin
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_RESET_WAIT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign instr_o        = instr_q;
    assign instr_valid_o  = instr_valid_q;
    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_plus4_d;
    assign retired_cnt_o  = retired_cnt_q;

endmodule
